// File: rtl/cordiv_job_ctrl_if.sv
// ---------------------------------------------------------------------------
// cordiv_job_ctrl_if
// Job request / result handshake bundle for cordiv_job_ctrl.
//   req_valid/req_ready : job request handshake (host -> controller)
//   req_dividend        : dividend, value/256
//   req_divisor         : divisor,  value/256
//   res_valid/res_ready : result handshake (controller -> host)
//   res_quot            : quotient ones count, 0..2^LOG_LEN
//   res_err             : divide-by-zero flag
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface cordiv_job_ctrl_if #(
  parameter int LOG_LEN = 8
) ();

  logic               req_valid;
  logic               req_ready;
  logic [7:0]         req_dividend;
  logic [7:0]         req_divisor;
  logic               res_valid;
  logic               res_ready;
  logic [LOG_LEN:0]   res_quot;
  logic               res_err;

  modport master (
    output req_valid, req_dividend, req_divisor, res_ready,
    input  req_ready, res_valid, res_quot, res_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, res_ready,
    output req_ready, res_valid, res_quot, res_err
  );

endinterface

// File: rtl/cordiv_job_ctrl.sv
// ---------------------------------------------------------------------------
// cordiv_job_ctrl
// Job-level sequencer for the stochastic correlated (regenerating) divider.
// Latches an 8-bit dividend/divisor job, clears the divider, runs WARMUP
// warm-up cycles, then counts quotient ones over 2^LOG_LEN cycles and returns
// the count over a result handshake. Operands are turned into bitstreams by
// an internal 8-bit LFSR stochastic number generator.
//
// Ports:
//   clk_i           clock
//   rst_n_i         synchronous active-low reset
//   abort_i         job abort (only with CORDIV_JOB_CTRL_ABORT_EN defined)
//   job_if          request/result handshake bundle (slave modport)
//   busy_o          high while in CLEAR/WARM/RUN
//   dp_rst_n_o      divider clear, active-low (combinational)
//   dp_randnum_o    regeneration random number to the divider
//   dp_sel_o        divider select
//   dp_dividend_o   dividend bitstream
//   dp_divisor_o    divisor bitstream
//   dp_quotient_i   divider output bit
//
// Optional feature macro: CORDIV_JOB_CTRL_ABORT_EN (adds abort_i).
// ---------------------------------------------------------------------------
module cordiv_job_ctrl #(
  parameter int LOG_LEN = 8,
  parameter int WARMUP  = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
`ifdef CORDIV_JOB_CTRL_ABORT_EN
  input  logic               abort_i,
`else
`endif
  cordiv_job_ctrl_if.slave   job_if,
  output logic               busy_o,
  output logic               dp_rst_n_o,
  output logic [7:0]         dp_randnum_o,
  output logic               dp_sel_o,
  output logic               dp_dividend_o,
  output logic               dp_divisor_o,
  input  logic               dp_quotient_i
);

  localparam int LEN_W = LOG_LEN + 1;
  // Phase counter must hold both WARMUP-1 (up to 254) and LEN-1.
  localparam int PH_W  = (LOG_LEN > 8) ? LOG_LEN : 8;

  localparam logic [LEN_W-1:0] LEN_C     = LEN_W'(1) << LOG_LEN;
  localparam logic [PH_W-1:0]  RUN_LAST  = PH_W'((1 << LOG_LEN) - 1);
  localparam logic [PH_W-1:0]  WARM_LAST = PH_W'(WARMUP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WARM  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         dividend_q, dividend_d;
  logic [7:0]         divisor_q, divisor_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [LEN_W-1:0]   ones_q, ones_d;
  logic [LEN_W-1:0]   quot_q, quot_d;
  logic               err_q, err_d;
  logic               res_valid_q, res_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic [7:0]         lfsr_next_s;
  logic               sng_active_s;

  // Fibonacci LFSR step, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Bit reversal decorrelates the divisor stream from the dividend stream.
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  assign lfsr_next_s = lfsr_step(lfsr_q);

  // Next-state and register-update logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    lfsr_d      = lfsr_q;
    phase_d     = phase_q;
    ones_d      = ones_q;
    quot_d      = quot_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone completes E0.
        if (job_if.req_valid) begin
          dividend_d = job_if.req_dividend;
          divisor_d  = job_if.req_divisor;
          state_d    = S_CLEAR;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CLEAR: begin
        lfsr_d  = 8'h01;
        ones_d  = '0;
        phase_d = '0;
        if (divisor_q == 8'h00) begin
          quot_d  = LEN_C;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (WARMUP == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_WARM;
        end
      end
      S_WARM: begin
        lfsr_d = lfsr_next_s;
        if (phase_q == WARM_LAST) begin
          phase_d = '0;
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_next_s;
        ones_d = ones_q + LEN_W'(dp_quotient_i);
        if (phase_q == RUN_LAST) begin
          // Final count includes this edge's quotient bit.
          quot_d  = ones_d;
          err_d   = 1'b0;
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        if (job_if.res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CORDIV_JOB_CTRL_ABORT_EN
    // Abort drops the job: result registers keep their previous values.
    if (abort_i && ((state_q == S_CLEAR) || (state_q == S_WARM) || (state_q == S_RUN))) begin
      state_d = S_IDLE;
      phase_d = '0;
      ones_d  = '0;
      quot_d  = quot_q;
      err_d   = err_q;
    end else begin
      state_d = state_d;
    end
`else
`endif

    res_valid_d = (state_d == S_DONE);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_WARM) || (state_d == S_RUN);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      dividend_q  <= 8'h00;
      divisor_q   <= 8'h00;
      lfsr_q      <= 8'h01;
      phase_q     <= '0;
      ones_q      <= '0;
      quot_q      <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      lfsr_q      <= lfsr_d;
      phase_q     <= phase_d;
      ones_q      <= ones_d;
      quot_q      <= quot_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign sng_active_s = (state_q == S_WARM) || (state_q == S_RUN);

  // Stochastic number generator: operand streams and regeneration controls.
  always_comb begin
    dp_dividend_o = 1'b0;
    dp_divisor_o  = 1'b0;
    dp_randnum_o  = 8'h00;
    dp_sel_o      = 1'b0;
    if (sng_active_s) begin
      dp_dividend_o = (dividend_q > lfsr_q);
      dp_divisor_o  = (divisor_q > bitrev8(lfsr_q));
      dp_randnum_o  = {lfsr_q[3:0], lfsr_q[7:4]};
      dp_sel_o      = lfsr_q[0];
    end else begin
      dp_dividend_o = 1'b0;
    end
  end

  // Divider clear follows the global reset as well as the CLEAR state.
  assign dp_rst_n_o = rst_n_i & (state_q != S_CLEAR);

  assign busy_o           = busy_q;
  assign job_if.req_ready = req_ready_q;
  assign job_if.res_valid = res_valid_q;
  assign job_if.res_quot  = quot_q;
  assign job_if.res_err   = err_q;

endmodule

// File: tb/tb_cordiv_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cordiv_job_ctrl
// Self-checking bench for cordiv_job_ctrl. The divider is replaced by a
// behavioural stand-in whose quotient bit is (randnum < threshold), where the
// threshold is the ideal ratio dividend*256/divisor saturated to 255. The
// reference model derives the expected streams and ones count directly from
// the LFSR sequence.
// ---------------------------------------------------------------------------
module tb_cordiv_job_ctrl;

  localparam int LOG_LEN = 8;
  localparam int WARMUP  = 16;
  localparam int LEN     = 1 << LOG_LEN;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       busy;
  logic       dp_rst_n;
  logic [7:0] dp_randnum;
  logic       dp_sel;
  logic       dp_dividend;
  logic       dp_divisor;
  logic       dp_quotient;
  logic [7:0] stub_thr;

  int n_vec;
  int n_err;
  int exp_quot;
  int exp_err;

  cordiv_job_ctrl_if #(.LOG_LEN(LOG_LEN)) jif ();

  cordiv_job_ctrl #(.LOG_LEN(LOG_LEN), .WARMUP(WARMUP)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
`ifdef CORDIV_JOB_CTRL_ABORT_EN
    .abort_i       (abort),
`endif
    .job_if        (jif.slave),
    .busy_o        (busy),
    .dp_rst_n_o    (dp_rst_n),
    .dp_randnum_o  (dp_randnum),
    .dp_sel_o      (dp_sel),
    .dp_dividend_o (dp_dividend),
    .dp_divisor_o  (dp_divisor),
    .dp_quotient_i (dp_quotient)
  );

  // Divider stand-in.
  assign dp_quotient = (dp_randnum < stub_thr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] thr_of(input int dvd, input int dvs);
    int t;
    if (dvs == 0) t = 255;
    else t = (dvd * 256) / dvs;
    if (t > 255) t = 255;
    return 8'(t);
  endfunction

  // Expected SNG outputs {dividend, divisor, sel, randnum} for a given LFSR value.
  function automatic logic [10:0] sng_of(input int dvd, input int dvs, input logic [7:0] l);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(dvd);
    b = 8'(dvs);
    return {(a > l), (b > rev8(l)), l[0], {l[3:0], l[7:4]}};
  endfunction

  // Expected ones count: WARMUP discarded steps, then LEN counted steps.
  function automatic int ref_quot(input int dvd, input int dvs);
    logic [7:0] l;
    logic [7:0] rn;
    logic [7:0] t;
    int cnt;
    if (dvs == 0) return LEN;
    t = thr_of(dvd, dvs);
    l = 8'h01;
    for (int i = 0; i < WARMUP; i++) l = lfsr_adv(l);
    cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      rn = {l[3:0], l[7:4]};
      if (rn < t) cnt++;
      l = lfsr_adv(l);
    end
    return cnt;
  endfunction

  function automatic logic [10:0] sng_now();
    return {dp_dividend, dp_divisor, dp_sel, dp_randnum};
  endfunction

  // Runs one job. hold: DONE cycles with res_ready low. rst_at/abort_at: cycle
  // index after E0 at which reset/abort is applied (-1 = never).
  task automatic run_job(input int dvd, input int dvs, input int hold,
                         input int rst_at, input int abort_at, output int got_quot);
    int lat;
    logic [7:0] l;
    got_quot = -1;
    for (int i = 0; i < 10 && !jif.req_ready; i++) step();
    chk("req_ready_idle", 32'(jif.req_ready), 32'd1);
    stub_thr          = thr_of(dvd, dvs);
    jif.res_ready     = (hold == 0);
    jif.req_valid     = 1'b1;
    jif.req_dividend  = 8'(dvd);
    jif.req_divisor   = 8'(dvs);
    step();  // E0
    jif.req_valid     = 1'b0;
    jif.req_dividend  = 8'($urandom);
    jif.req_divisor   = 8'($urandom);
    chk("clear_dp_rst_n", 32'(dp_rst_n), 32'd0);
    chk("clear_sng", 32'(sng_now()), 32'd0);
    chk("clear_busy_ready", 32'({busy, jif.req_ready}), 32'b10);
    lat = (dvs == 0) ? 1 : 1 + WARMUP + LEN;
    l = 8'h01;
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == rst_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_quot = 0;
        exp_err  = 0;
        chk("rst_flags", 32'({jif.req_ready, jif.res_valid, busy}), 32'b100);
        chk("rst_quot", 32'(jif.res_quot), 32'd0);
        chk("rst_err", 32'(jif.res_err), 32'd0);
        chk("rst_sng", 32'(sng_now()), 32'd0);
        return;
      end
`ifdef CORDIV_JOB_CTRL_ABORT_EN
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flags", 32'({jif.req_ready, jif.res_valid, busy}), 32'b100);
        chk("abort_quot", 32'(jif.res_quot), 32'(exp_quot));
        chk("abort_sng", 32'(sng_now()), 32'd0);
        return;
      end
`endif
      if (k == 1) chk("dp_rst_n_release", 32'(dp_rst_n), 32'd1);
      if (k < lat) begin
        chk("sng_valid", 32'({jif.res_valid, sng_now()}), 32'({1'b0, sng_of(dvd, dvs, l)}));
        l = lfsr_adv(l);
      end else begin
        chk("done_valid_sng", 32'({jif.res_valid, sng_now()}), 32'h800);
      end
    end
    exp_quot = ref_quot(dvd, dvs);
    exp_err  = (dvs == 0) ? 1 : 0;
    got_quot = int'(jif.res_quot);
    chk("res_quot", 32'(jif.res_quot), 32'(exp_quot));
    chk("res_err", 32'(jif.res_err), 32'(exp_err));
    chk("done_busy_ready", 32'({busy, jif.req_ready}), 32'b00);
    for (int h = 0; h < hold; h++) begin
      jif.req_valid = (h == 2);
      step();
      jif.req_valid = 1'b0;
      chk("hold_valid_ready", 32'({jif.res_valid, jif.req_ready, busy}), 32'b100);
      chk("hold_quot_err", 32'({jif.res_err, jif.res_quot}), 32'({exp_err[0], 9'(exp_quot)}));
    end
    jif.res_ready = 1'b1;
    step();
    chk("release_ready_valid", 32'({jif.req_ready, jif.res_valid, busy}), 32'b100);
    chk("kept_quot_err", 32'({jif.res_err, jif.res_quot}), 32'({exp_err[0], 9'(exp_quot)}));
  endtask

  initial begin
    int q;
    int dvd;
    int dvs;
    n_vec = 0;
    n_err = 0;
    exp_quot = 0;
    exp_err  = 0;
    rst_n = 1'b0;
    abort = 1'b0;
    stub_thr = 8'h00;
    jif.req_valid    = 1'b0;
    jif.req_dividend = 8'h00;
    jif.req_divisor  = 8'h00;
    jif.res_ready    = 1'b1;
    step();
    step();
    chk("reset_flags", 32'({jif.req_ready, jif.res_valid, busy, dp_rst_n}), 32'b1000);
    chk("reset_quot_err", 32'({jif.res_err, jif.res_quot}), 32'd0);
    chk("reset_sng", 32'(sng_now()), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_reset_dp_rst_n", 32'(dp_rst_n), 32'd1);

    // Nominal job with result around half of LEN.
    run_job(64, 128, 0, -1, -1, q);
    chk("s1_window", 32'((q >= 104) && (q <= 152)), 32'd1);

    // Divide by zero.
    run_job(200, 0, 0, -1, -1, q);
    chk("s2_quot", 32'(q), 32'(LEN));

    // Zero dividend, replayed.
    run_job(0, 200, 0, -1, -1, q);
    chk("s3_small", 32'(q <= 8), 32'd1);
    run_job(0, 200, 0, -1, -1, q);
    chk("s3_small_replay", 32'(q <= 8), 32'd1);

    // Backpressure in DONE.
    run_job(100, 150, 20, -1, -1, q);

    // Reset in RUN cycle 100, then a normal job.
    run_job(64, 128, 0, WARMUP + 100, -1, q);
    run_job(64, 128, 0, -1, -1, q);
    chk("s5_window", 32'((q >= 104) && (q <= 152)), 32'd1);

`ifdef CORDIV_JOB_CTRL_ABORT_EN
    run_job(64, 128, 0, -1, 5, q);
    run_job(64, 128, 0, -1, -1, q);
    chk("s6_quot", 32'(q), 32'(ref_quot(64, 128)));
`endif

    // Randomized jobs, including divide-by-zero and dividend > divisor.
    for (int j = 0; j < 8; j++) begin
      dvd = int'($urandom_range(0, 255));
      dvs = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
      run_job(dvd, dvs, int'($urandom_range(0, 3)), -1, -1, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
